opsum_reducer: RTL

Accumulates per-row partial sums from the PE array across multiple input-channel passes, then requantizes each active row to int8 and streams the results out one row per cycle. It sits directly downstream of the PE array and consumes its packed `array_opsum` bus during Compute. It feeds the output buffer through a valid/ready handshake.

---
 rtl/opsum_reducer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/opsum_reducer.sv
// opsum_reducer: accumulates per-row PE partial sums over several passes,
// then requantizes each active row to int8 and streams rows out one per cycle.
module opsum_reducer #(
  parameter int unsigned ROW_NUM = 32,
  parameter int unsigned PSUM_W  = 16,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  num_pass,
  input  logic [5:0]                  row_en,
  input  logic                        relu_en,
  input  logic [4:0]                  shift,
  input  logic [ROW_NUM*PSUM_W-1:0]   array_opsum,
  input  logic                        opsum_valid,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [7:0]                  out_data,
  output logic [4:0]                  out_row,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        drop_err
);

  localparam int unsigned IDX_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam logic [5:0]  ROW_MAX = 6'(ROW_NUM);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                    state_q;
  logic [7:0]                num_pass_q;
  logic [5:0]                row_en_q;
  logic                      relu_q;
  logic [4:0]                shift_q;
  logic [7:0]                pass_cnt_q;
  logic [5:0]                row_idx_q;
  logic signed [ACC_W-1:0]   acc_q [ROW_NUM];

  logic                      out_valid_q;
  logic [7:0]                out_data_q;
  logic [4:0]                out_row_q;
  logic                      out_last_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      drop_err_q;

  logic signed [ACC_W-1:0]   psum_ext [ROW_NUM];
  logic [5:0]                row_en_d;
  logic [7:0]                num_pass_d;
  logic [5:0]                row_nxt_d;
  logic                      final_beat_d;
  logic signed [ACC_W-1:0]   acc0_d;
  logic signed [ACC_W-1:0]   acc_nxt_d;

  // Round-half-up shift, optional ReLU, then saturate to int8.
  function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] a,
                                         input logic [4:0]              sh,
                                         input logic                    relu);
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] t;
    logic [7:0]              res;
    rnd = '0;
    if (sh != 5'd0) rnd = ACC_W'(1) << (sh - 5'd1);
    t = (a + rnd) >>> sh;
    if (relu && t[ACC_W-1]) t = '0;
    if (t > SAT_MAX)      res = 8'h7f;
    else if (t < SAT_MIN) res = 8'h80;
    else                  res = t[7:0];
    return res;
  endfunction

  // Sign-extend each incoming row sum to accumulator width.
  always_comb begin
    for (int r = 0; r < int'(ROW_NUM); r++) begin
      psum_ext[r] = ACC_W'($signed(array_opsum[r*PSUM_W +: PSUM_W]));
    end
  end

  // Configuration sanitising and datapath helpers for the state register.
  always_comb begin
    row_en_d = row_en;
    if (row_en == 6'd0)        row_en_d = 6'd1;
    else if (row_en > ROW_MAX) row_en_d = ROW_MAX;
    num_pass_d   = (num_pass == 8'd0) ? 8'd1 : num_pass;
    row_nxt_d    = row_idx_q + 6'd1;
    final_beat_d = opsum_valid && (pass_cnt_q == num_pass_q - 8'd1);
    acc0_d       = acc_q[0] + psum_ext[0];
    acc_nxt_d    = acc_q[IDX_W'(row_nxt_d)];
  end

  // Control FSM, accumulators and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_pass_q  <= 8'd1;
      row_en_q    <= 6'd1;
      relu_q      <= 1'b0;
      shift_q     <= 5'd0;
      pass_cnt_q  <= 8'd0;
      row_idx_q   <= 6'd0;
      for (int r = 0; r < int'(ROW_NUM); r++) acc_q[r] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_row_q   <= 5'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_ACCUM;
            num_pass_q <= num_pass_d;
            row_en_q   <= row_en_d;
            relu_q     <= relu_en;
            shift_q    <= shift;
            pass_cnt_q <= 8'd0;
            row_idx_q  <= 6'd0;
            for (int r = 0; r < int'(ROW_NUM); r++) acc_q[r] <= '0;
            busy_q     <= 1'b1;
            drop_err_q <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (opsum_valid) begin
            // Rows beyond the active count are left at zero.
            for (int r = 0; r < int'(ROW_NUM); r++) begin
              if (6'(r) < row_en_q) acc_q[r] <= acc_q[r] + psum_ext[r];
            end
            pass_cnt_q <= pass_cnt_q + 8'd1;
            if (final_beat_d) begin
              // Row 0 is presented straight away, folding in this last beat.
              state_q     <= S_DRAIN;
              row_idx_q   <= 6'd0;
              out_valid_q <= 1'b1;
              out_row_q   <= 5'd0;
              out_last_q  <= (row_en_q == 6'd1);
              out_data_q  <= requant(acc0_d, shift_q, relu_q);
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= 8'd0;
              out_row_q   <= 5'd0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              row_idx_q  <= row_nxt_d;
              out_row_q  <= 5'(row_nxt_d);
              out_last_q <= (row_nxt_d == row_en_q - 6'd1);
              out_data_q <= requant(acc_nxt_d, shift_q, relu_q);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      // Placed last so a beat arriving with start still raises the flag.
      if (opsum_valid && (state_q != S_ACCUM)) drop_err_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign drop_err  = drop_err_q;

endmodule
